// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-port memory between instruction fetch and data access with a fixed-latency FSM.
// Optional single-entry fetch buffer enabled by defining MEM_PORT_ARBITER_IBUF_EN.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall_f,
    output logic              stall_m,
    output logic              busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_CAPT,
        S_DONE
    } state_t;

    localparam logic [3:0] LAT_INIT   = 4'(MEM_LAT - 1);
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t            r_state;
    state_t            w_next;
    logic              r_owner_f;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [3:0]        r_lat_cnt;
    logic [3:0]        r_starve;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_d_rdata;
    logic              w_grant_d;
    logic              w_grant_f;
    logic              w_hit;

`ifdef MEM_PORT_ARBITER_IBUF_EN
    logic              r_buf_vld;
    logic [ADDR_W-1:0] r_buf_addr;
    logic [DATA_W-1:0] r_buf_data;
`endif

    // Data has priority unless the fetch has been passed over STARVE_MAX times in a row.
    always_comb begin
        w_grant_d = d_req & (~if_req | (r_starve != STARVE_LIM));
        w_grant_f = if_req & ~w_grant_d;
        w_hit     = 1'b0;
`ifdef MEM_PORT_ARBITER_IBUF_EN
        w_hit     = if_req & ~d_req & r_buf_vld & (if_addr == r_buf_addr);
`endif
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_hit) begin
                    w_next = S_DONE;
                end else if (w_grant_d || w_grant_f) begin
                    w_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (r_we) begin
                    w_next = S_DONE;
                end else if (MEM_LAT == 1) begin
                    w_next = S_CAPT;
                end else begin
                    w_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_lat_cnt <= 4'd1) begin
                    w_next = S_CAPT;
                end
            end
            S_CAPT:  w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_owner_f  <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_lat_cnt  <= '0;
            r_starve   <= '0;
            r_if_rdata <= '0;
            r_d_rdata  <= '0;
`ifdef MEM_PORT_ARBITER_IBUF_EN
            r_buf_vld  <= 1'b0;
            r_buf_addr <= '0;
            r_buf_data <= '0;
`endif
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (!if_req || w_grant_f || w_hit) begin
                        r_starve <= '0;
                    end else if (w_grant_d && (r_starve != STARVE_LIM)) begin
                        r_starve <= r_starve + 4'd1;
                    end
                    if (w_hit) begin
                        r_owner_f <= 1'b1;
                        r_we      <= 1'b0;
`ifdef MEM_PORT_ARBITER_IBUF_EN
                        r_if_rdata <= r_buf_data;
`endif
                    end else if (w_grant_d) begin
                        r_owner_f <= 1'b0;
                        r_we      <= d_we;
                        r_addr    <= d_addr;
                        r_wdata   <= d_wdata;
                    end else if (w_grant_f) begin
                        r_owner_f <= 1'b1;
                        r_we      <= 1'b0;
                        r_addr    <= if_addr;
                    end
                end
                S_ISSUE: begin
                    r_lat_cnt <= LAT_INIT;
`ifdef MEM_PORT_ARBITER_IBUF_EN
                    if (r_we && r_buf_vld && (r_addr == r_buf_addr)) begin
                        r_buf_vld <= 1'b0;
                    end
`endif
                end
                S_WAIT: begin
                    r_lat_cnt <= r_lat_cnt - 4'd1;
                end
                S_CAPT: begin
                    if (r_owner_f) begin
                        r_if_rdata <= mem_rdata;
`ifdef MEM_PORT_ARBITER_IBUF_EN
                        r_buf_vld  <= 1'b1;
                        r_buf_addr <= r_addr;
                        r_buf_data <= mem_rdata;
`endif
                    end else begin
                        r_d_rdata <= mem_rdata;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign mem_en    = (r_state == S_ISSUE);
    assign mem_we    = mem_en & r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign if_ready  = (r_state == S_DONE) & r_owner_f;
    assign d_ready   = (r_state == S_DONE) & ~r_owner_f;
    assign if_rdata  = r_if_rdata;
    assign d_rdata   = r_d_rdata;
    assign stall_f   = if_req & ~if_ready;
    assign stall_m   = d_req & ~d_ready;
    assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus pushes expected memory strobes and ready pulses,
// a negedge monitor pops and compares them. Extra instances cover MEM_LAT=1 and MEM_LAT=15.
module tb_mem_port_arbiter;

    localparam int LAT = 2;

    typedef struct {
        bit          f;
        bit          we;
        logic [31:0] data;
        int          cyc;
    } rdy_t;

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          cyc;
    } mem_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [31:0] d_rdata;
    logic        d_ready;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        stall_f;
    logic        stall_m;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    rdy_t rdy_q[$];
    mem_t mem_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT), .STARVE_MAX(4)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .stall_f(stall_f), .stall_m(stall_m), .busy(busy)
    );

    // Memory model: unwritten words return a fixed per-address pattern.
    logic [31:0] wr_data [0:255];
    bit          wr_vld  [0:255];
    int          m_cnt = 0;
    logic [31:0] m_addr = '0;

    function automatic logic [31:0] init_val(input logic [31:0] a);
        case (a)
            32'h10:  return 32'h8C01_0004;
            32'h30:  return 32'hA5A5_0030;
            32'h40:  return 32'h1234_0040;
            default: return {16'hC0DE, a[15:0]};
        endcase
    endfunction

    function automatic logic [31:0] rd(input logic [31:0] a);
        return wr_vld[a[9:2]] ? wr_data[a[9:2]] : init_val(a);
    endfunction

    always @(posedge clk) begin
        if (mem_en && mem_we) begin
            wr_data[mem_addr[9:2]] <= mem_wdata;
            wr_vld[mem_addr[9:2]]  <= 1'b1;
        end
        if (mem_en && !mem_we) begin
            m_cnt  <= LAT;
            m_addr <= mem_addr;
        end else if (m_cnt != 0) begin
            m_cnt <= m_cnt - 1;
        end
    end
    assign mem_rdata = (m_cnt == 1) ? rd(m_addr) : 32'hBAD0_BAD0;

    // Latency-corner instances, fetch only.
    logic        l1_req = 1'b0, l15_req = 1'b0;
    logic [31:0] l1_ifd, l15_ifd, l1_dd, l15_dd, l1_ma, l15_ma, l1_mw, l15_mw, l1_mr, l15_mr;
    logic        l1_rdy, l15_rdy, l1_drdy, l15_drdy, l1_en, l15_en, l1_we, l15_we;
    logic        l1_sf, l15_sf, l1_sm, l15_sm, l1_busy, l15_busy;
    int          c1 = 0, c15 = 0;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(4)) u_l1 (
        .clk(clk), .rst(rst),
        .if_req(l1_req), .if_addr(32'h50), .if_rdata(l1_ifd), .if_ready(l1_rdy),
        .d_req(1'b0), .d_we(1'b0), .d_addr(32'h0), .d_wdata(32'h0),
        .d_rdata(l1_dd), .d_ready(l1_drdy),
        .mem_en(l1_en), .mem_we(l1_we), .mem_addr(l1_ma), .mem_wdata(l1_mw),
        .mem_rdata(l1_mr), .stall_f(l1_sf), .stall_m(l1_sm), .busy(l1_busy)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(15), .STARVE_MAX(4)) u_l15 (
        .clk(clk), .rst(rst),
        .if_req(l15_req), .if_addr(32'h50), .if_rdata(l15_ifd), .if_ready(l15_rdy),
        .d_req(1'b0), .d_we(1'b0), .d_addr(32'h0), .d_wdata(32'h0),
        .d_rdata(l15_dd), .d_ready(l15_drdy),
        .mem_en(l15_en), .mem_we(l15_we), .mem_addr(l15_ma), .mem_wdata(l15_mw),
        .mem_rdata(l15_mr), .stall_f(l15_sf), .stall_m(l15_sm), .busy(l15_busy)
    );

    always @(posedge clk) begin
        if (l1_en) c1 <= 1; else if (c1 != 0) c1 <= c1 - 1;
        if (l15_en) c15 <= 15; else if (c15 != 0) c15 <= c15 - 1;
    end
    assign l1_mr  = (c1 == 1)  ? 32'h0000_1111 : 32'hBAD0_BAD0;
    assign l15_mr = (c15 == 1) ? 32'h0000_1515 : 32'hBAD0_BAD0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string nm);
        n_tests++;
        n_fail++;
        $display("FAIL %s: unexpected event (cycle %0d)", nm, cyc);
    endtask

    // Monitor: pops expectations whenever the DUT strobes memory or pulses ready.
    always @(negedge clk) begin
        if (if_ready && d_ready) fail_now("both_ready");
        if (if_ready || d_ready) begin
            if (rdy_q.size() == 0) begin
                fail_now("ready_unexpected");
            end else begin
                rdy_t e;
                e = rdy_q.pop_front();
                chk("ready_owner", {31'b0, if_ready}, {31'b0, e.f});
                chk("ready_cycle", cyc, e.cyc);
                if (!e.we) chk("rdata", e.f ? if_rdata : d_rdata, e.data);
            end
        end
        if (mem_en) begin
            if (mem_q.size() == 0) begin
                fail_now("mem_en_unexpected");
            end else begin
                mem_t m;
                m = mem_q.pop_front();
                chk("mem_we", {31'b0, mem_we}, {31'b0, m.we});
                chk("mem_addr", mem_addr, m.addr);
                chk("mem_cycle", cyc, m.cyc);
                if (m.we) chk("mem_wdata", mem_wdata, m.wdata);
            end
        end
    end

    task automatic access(input bit f, input bit we, input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] exp, input bit go_mem);
        int t0;
        bit seen;
        @(posedge clk); #1;
        t0 = cyc;
        if (go_mem) mem_q.push_back('{we, a, wd, t0 + 1});
        rdy_q.push_back('{f, we, exp, go_mem ? (we ? t0 + 2 : t0 + 2 + LAT) : t0 + 1});
        if (f) begin
            if_addr = a; if_req = 1'b1;
        end else begin
            d_addr = a; d_we = we; d_wdata = wd; d_req = 1'b1;
        end
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (f ? if_ready : d_ready) seen = 1'b1;
            else chk("stall_pending", {31'b0, f ? stall_f : stall_m}, 32'd1);
        end
        chk("ready_seen", {31'b0, seen}, 32'd1);
        chk("stall_at_ready", {31'b0, f ? stall_f : stall_m}, 32'd0);
        @(posedge clk); #1;
        if (f) if_req = 1'b0; else d_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, t1, t15;
        logic [31:0] v1, v15;
        bit drop1, drop15;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_mem_en", {31'b0, mem_en}, 32'd0);
        chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_if_rdata", if_rdata, 32'd0);
        chk("rst_d_rdata", d_rdata, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        access(1'b1, 1'b0, 32'h10, 32'h0, 32'h8C01_0004, 1'b1);
        access(1'b0, 1'b1, 32'h20, 32'hDEAD_BEEF, 32'h0, 1'b1);
        access(1'b0, 1'b0, 32'h20, 32'h0, 32'hDEAD_BEEF, 1'b1);
        chk("if_rdata_hold", if_rdata, 32'h8C01_0004);

        // Both requesters pending: D,D,D,D,F repeated, five cycles per read access.
        @(posedge clk); #1;
        t0 = cyc;
        for (int k = 0; k < 10; k++) begin
            bit fk;
            fk = (k == 4) || (k == 9);
            mem_q.push_back('{1'b0, fk ? 32'h30 : 32'h40, 32'h0, t0 + 1 + 5 * k});
            rdy_q.push_back('{fk, 1'b0, fk ? 32'hA5A5_0030 : 32'h1234_0040, t0 + 4 + 5 * k});
        end
        if_addr = 32'h30; d_addr = 32'h40; d_we = 1'b0;
        if_req = 1'b1; d_req = 1'b1;
        repeat (50) @(posedge clk);
        #1;
        if_req = 1'b0; d_req = 1'b0;
        repeat (3) @(posedge clk);

        // Reset during WAIT aborts the fetch.
        @(posedge clk); #1;
        t0 = cyc;
        mem_q.push_back('{1'b0, 32'h40, 32'h0, t0 + 1});
        if_addr = 32'h40; if_req = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("wait_busy", {31'b0, busy}, 32'd1);
        rst = 1'b1; if_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_if_ready", {31'b0, if_ready}, 32'd0);
        chk("abort_mem_en", {31'b0, mem_en}, 32'd0);
        chk("abort_mem_addr", mem_addr, 32'd0);
        chk("abort_if_rdata", if_rdata, 32'd0);
        chk("abort_d_rdata", d_rdata, 32'd0);
        repeat (6) @(posedge clk);

        // Latency corners.
        @(posedge clk); #1;
        t0 = cyc; t1 = -1; t15 = -1; v1 = '0; v15 = '0;
        l1_req = 1'b1; l15_req = 1'b1;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            drop1 = 1'b0; drop15 = 1'b0;
            if (l1_rdy)  begin t1 = cyc - t0;  v1 = l1_ifd;  drop1 = 1'b1; end
            if (l15_rdy) begin t15 = cyc - t0; v15 = l15_ifd; drop15 = 1'b1; end
            @(posedge clk); #1;
            if (drop1) l1_req = 1'b0;
            if (drop15) l15_req = 1'b0;
        end
        chk("lat1_ready_cycle", t1, 32'd3);
        chk("lat1_rdata", v1, 32'h0000_1111);
        chk("lat15_ready_cycle", t15, 32'd17);
        chk("lat15_rdata", v15, 32'h0000_1515);
        l1_req = 1'b0; l15_req = 1'b0;

`ifdef MEM_PORT_ARBITER_IBUF_EN
        access(1'b1, 1'b0, 32'h10, 32'h0, 32'h8C01_0004, 1'b1);
        access(1'b1, 1'b0, 32'h10, 32'h0, 32'h8C01_0004, 1'b0);
        access(1'b0, 1'b1, 32'h10, 32'h0BAD_F00D, 32'h0, 1'b1);
        access(1'b1, 1'b0, 32'h10, 32'h0, 32'h0BAD_F00D, 1'b1);
`endif

        repeat (5) @(posedge clk);
        chk("rdy_q_empty", rdy_q.size(), 32'd0);
        chk("mem_q_empty", mem_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port unified memory between the pipeline's instruction-fetch (IF) stage and its data-memory (MEM) stage.
- Selects which requester owns the port, sequences each access through a fixed-latency FSM, and returns read data with a one-cycle ready pulse.
- Drives stall_f and stall_m to the hazard logic so the pipeline stages hold while their access is outstanding.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MEM_LAT, 2, cycles from the mem_en cycle to the cycle mem_rdata is valid; legal range 1..15
- STARVE_MAX, 4, consecutive data grants made while a fetch waits before the fetch is forced next; legal range 1..15

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-high
- if_req  in  1  fetch request, held until if_ready
- if_addr  in  ADDR_W  fetch address
- if_rdata  out  DATA_W  fetched word, valid while if_ready=1
- if_ready  out  1  one-cycle completion pulse
- d_req  in  1  data request, held until d_ready
- d_we  in  1  1=write, 0=read
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  write data
- d_rdata  out  DATA_W  read data, valid while d_ready=1
- d_ready  out  1  one-cycle completion pulse
- mem_en  out  1  memory access strobe, one cycle per access
- mem_we  out  1  memory write enable, qualified by mem_en
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after the mem_en cycle
- stall_f  out  1  if_req & ~if_ready
- stall_m  out  1  d_req & ~d_ready
- busy  out  1  FSM not in IDLE

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous, active-high.
- Reset values: FSM=IDLE; mem_en, mem_we, if_ready, d_ready = 0; mem_addr, mem_wdata, if_rdata, d_rdata = 0; latency counter = 0; starve counter = 0.
- Reset asserted mid-access aborts it: no ready pulse is issued and the memory result is discarded.
- FSM states and transitions:
  - IDLE: sample requests at the clock edge; on a grant, latch owner/addr/we/wdata into registers and go to ISSUE.
  - ISSUE: mem_en=1 for exactly this cycle with the latched fields. Write -> DONE. Read -> WAIT with counter=MEM_LAT-1; if MEM_LAT=1, go straight to CAPT.
  - WAIT: decrement counter each cycle; at 0 -> CAPT.
  - CAPT: mem_rdata is valid this cycle; register it into the owner's rdata -> DONE.
  - DONE: owner's ready=1 for this cycle only; requests are not sampled -> IDLE.
- Read latency, request sampled at end of cycle 0: mem_en in cycle 1, rdata valid in cycle 1+MEM_LAT, ready in cycle 2+MEM_LAT (cycle 4 at the default MEM_LAT).
- Write latency: mem_en in cycle 1, d_ready in cycle 2.
- Minimum one idle cycle between accesses, because DONE never grants.
- Arbitration when both requests are pending in IDLE:
  - Data wins, unless starve counter == STARVE_MAX, in which case the fetch wins.
  - Starve counter increments on each data grant made while if_req=1 (saturates at STARVE_MAX).
  - Starve counter clears on any fetch grant, or whenever if_req=0 in IDLE.
- Request rules:
  - A requester must hold req and its fields stable until its ready pulse. Fields are latched at grant, so later changes do not affect an access in flight.
  - Dropping req before ready is illegal; the arbiter still completes the access and pulses ready.
- The non-owner's ready stays 0. if_rdata and d_rdata hold their value between pulses.

Optional Feature:
- Macro MEM_PORT_ARBITER_IBUF_EN enables a single-entry fetch buffer: a registered {valid, addr, data}.
  - Filled on every completed fetch.
  - In IDLE, if if_req=1, d_req=0 and if_addr==buf addr with valid=1: skip memory, go directly to DONE (if_ready in cycle 1), and mem_en stays 0.
  - A data write whose d_addr equals the buffered addr clears valid in its ISSUE cycle.
  - Reset clears valid.
- Without the macro: no buffer; every fetch goes to memory.

Test Plan:
- Fetch only, MEM_LAT=2, if_addr=0x10, mem returns 0x8C010004 -> mem_en=1/mem_we=0/mem_addr=0x10 in cycle 1; if_ready=1 and if_rdata=0x8C010004 in cycle 4 only; stall_f=1 in cycles 0-3.
- Data write d_addr=0x20, d_wdata=0xDEADBEEF -> mem_en=1, mem_we=1, mem_wdata=0xDEADBEEF in cycle 1; d_ready in cycle 2.
- Both requests continuously pending, STARVE_MAX=4 -> grant order D,D,D,D,F,D,D,D,D,F; no grant in any DONE cycle.
- rst=1 in the WAIT cycle of a read at 0x40 -> no if_ready, busy=0 the next cycle, all outputs 0.
- MEM_LAT=1 read -> ready in cycle 3; MEM_LAT=15 read -> ready in cycle 17.
- With MEM_PORT_ARBITER_IBUF_EN: fetch 0x10 twice -> second has if_ready in cycle 1 and no mem_en; then write 0x10 and fetch 0x10 -> memory access occurs.
